// File: rtl/time_keeper.sv
// time_keeper: hour/minute/second clock with a run mode and two set modes.
//
// Ports:
//   clk        system clock; all state updates on its rising edge
//   rst        asynchronous active-low reset
//   tick_in    divided clock from the upstream divider, sampled as data
//   mode_btn   single-cycle pulse: RUN -> SET_HR -> SET_MIN -> RUN
//   inc_btn    single-cycle pulse: increments the field selected by mode
//   hour       current hour, 0..HOUR_MOD-1
//   min        current minute, 0..59
//   sec        current second, 0..59
//   mode       0 RUN, 1 SET_HR, 2 SET_MIN
//   day_pulse  one-cycle pulse after the hour wraps to 0 while running
module time_keeper #(
    parameter int unsigned HOUR_MOD   = 24,
    parameter int unsigned START_HOUR = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic [1:0] mode,
    output logic       day_pulse
);

    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MS_W   = 6;

    localparam logic [HOUR_W-1:0] HOUR_LAST  = HOUR_W'(HOUR_MOD - 1);
    localparam logic [HOUR_W-1:0] HOUR_RESET = HOUR_W'(START_HOUR);
    localparam logic [MS_W-1:0]   MS_LAST    = MS_W'(59);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } state_t;

    state_t            state_q,  state_nxt;
    logic [HOUR_W-1:0] hour_q,   hour_nxt;
    logic [MS_W-1:0]   min_q,    min_nxt;
    logic [MS_W-1:0]   sec_q,    sec_nxt;
    logic              day_q,    day_nxt;
    logic              tick_d;
    logic              tick_evt_c;

    // Rising edge of tick_in; a level held high counts only once.
    assign tick_evt_c = tick_in & ~tick_d;

    // State and field registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            hour_q  <= HOUR_RESET;
            min_q   <= '0;
            sec_q   <= '0;
            day_q   <= 1'b0;
            tick_d  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            hour_q  <= hour_nxt;
            min_q   <= min_nxt;
            sec_q   <= sec_nxt;
            day_q   <= day_nxt;
            tick_d  <= tick_in;
        end
    end

    // Next-state and field update; mode_btn takes priority over tick and inc.
    always_comb begin
        state_nxt = state_q;
        hour_nxt  = hour_q;
        min_nxt   = min_q;
        sec_nxt   = sec_q;
        day_nxt   = 1'b0;

        case (state_q)
            RUN: begin
                if (mode_btn) begin
                    state_nxt = SET_HR;
                end else if (tick_evt_c) begin
                    if (sec_q == MS_LAST) begin
                        sec_nxt = '0;
                        if (min_q == MS_LAST) begin
                            min_nxt = '0;
                            if (hour_q == HOUR_LAST) begin
                                hour_nxt = '0;
                                day_nxt  = 1'b1;
                            end else begin
                                hour_nxt = hour_q + HOUR_W'(1);
                            end
                        end else begin
                            min_nxt = min_q + MS_W'(1);
                        end
                    end else begin
                        sec_nxt = sec_q + MS_W'(1);
                    end
                end
            end

            SET_HR: begin
                if (mode_btn) begin
                    state_nxt = SET_MIN;
                end else if (inc_btn) begin
                    hour_nxt = (hour_q == HOUR_LAST) ? '0 : hour_q + HOUR_W'(1);
                end
            end

            SET_MIN: begin
                if (mode_btn) begin
                    state_nxt = RUN;
                    sec_nxt   = '0;
                end else if (inc_btn) begin
                    min_nxt = (min_q == MS_LAST) ? '0 : min_q + MS_W'(1);
                end
            end

            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    assign hour      = hour_q;
    assign min       = min_q;
    assign sec       = sec_q;
    assign mode      = state_q;
    assign day_pulse = day_q;

endmodule

// File: tb/tb_time_keeper.sv
// Testbench for time_keeper: directed scenarios followed by random stimulus,
// all checked against a time-of-day model kept as plain integers.
module tb_time_keeper;

    localparam int unsigned HOUR_MOD   = 24;
    localparam int unsigned START_HOUR = 0;

    logic       clk;
    logic       rst;
    logic       tick_in;
    logic       mode_btn;
    logic       inc_btn;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [1:0] mode;
    logic       day_pulse;

    int n_cmp;
    int n_err;

    // Reference model state.
    int m_mode;
    int m_h;
    int m_m;
    int m_s;
    int m_day;
    int m_prev;

    time_keeper #(
        .HOUR_MOD  (HOUR_MOD),
        .START_HOUR(START_HOUR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_in  (tick_in),
        .mode_btn (mode_btn),
        .inc_btn  (inc_btn),
        .hour     (hour),
        .min      (min),
        .sec      (sec),
        .mode     (mode),
        .day_pulse(day_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_h    = START_HOUR;
        m_m    = 0;
        m_s    = 0;
        m_day  = 0;
        m_prev = 0;
    endtask

    // One clock of behaviour, expressed as seconds-of-day arithmetic.
    task automatic model_step(input logic mb, input logic ib, input logic ti);
        int  t;
        bit  ev;
        ev     = (ti == 1'b1) && (m_prev == 0);
        m_prev = int'(ti);
        m_day  = 0;
        case (m_mode)
            0: begin
                if (mb) m_mode = 1;
                else if (ev) begin
                    t = m_h * 3600 + m_m * 60 + m_s + 1;
                    if (t == int'(HOUR_MOD) * 3600) begin
                        t     = 0;
                        m_day = 1;
                    end
                    m_h = t / 3600;
                    m_m = (t / 60) % 60;
                    m_s = t % 60;
                end
            end
            1: begin
                if (mb) m_mode = 2;
                else if (ib) m_h = (m_h + 1) % int'(HOUR_MOD);
            end
            default: begin
                if (mb) begin
                    m_mode = 0;
                    m_s    = 0;
                end else if (ib) m_m = (m_m + 1) % 60;
            end
        endcase
    endtask

    task automatic check_all();
        check_eq("hour", int'(hour), m_h);
        check_eq("min", int'(min), m_m);
        check_eq("sec", int'(sec), m_s);
        check_eq("mode", int'(mode), m_mode);
        check_eq("day_pulse", int'(day_pulse), m_day);
    endtask

    // Called just after a rising edge: drive inputs, advance one clock, check.
    task automatic cycle(input logic mb, input logic ib, input logic ti);
        mode_btn = mb;
        inc_btn  = ib;
        tick_in  = ti;
        model_step(mb, ib, ti);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic tick_once();
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b0;
        tick_in  = 1'b0;
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        model_reset();

        // Reset values held across clock edges.
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;

        // Three tick events from reset.
        repeat (3) tick_once();
        check_eq("three_ticks_sec", int'(sec), 3);
        check_eq("three_ticks_hour", int'(hour), 0);

        // Set 23:59, return to RUN, then run seconds up to 23:59:59.
        cycle(1'b1, 1'b0, 1'b0);
        repeat (23) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        repeat (59) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        check_eq("set_exit_sec", int'(sec), 0);
        repeat (59) tick_once();
        check_eq("pre_wrap_sec", int'(sec), 59);
        check_eq("pre_wrap_hour", int'(hour), 23);
        cycle(1'b0, 1'b0, 1'b1);
        check_eq("wrap_day_pulse", int'(day_pulse), 1);
        check_eq("wrap_hour", int'(hour), 0);
        check_eq("wrap_min", int'(min), 0);
        cycle(1'b0, 1'b0, 1'b0);
        check_eq("wrap_day_pulse_off", int'(day_pulse), 0);

        // Hour edit with ticks interleaved: 25 increments wrap to 1.
        repeat (5) tick_once();
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 25; i++) begin
            cycle(1'b0, 1'b1, 1'b1);
            cycle(1'b0, 1'b0, 1'b0);
        end
        check_eq("set_hr_hour", int'(hour), 1);
        check_eq("set_hr_sec_held", int'(sec), 5);

        // Minute edit wraps without carrying into hour.
        cycle(1'b1, 1'b0, 1'b0);
        repeat (59) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        check_eq("min_wrap_min", int'(min), 0);
        check_eq("min_wrap_hour", int'(hour), 1);
        cycle(1'b1, 1'b0, 1'b0);
        check_eq("exit_mode", int'(mode), 0);
        check_eq("exit_sec", int'(sec), 0);

        // mode_btn beats a simultaneous tick.
        tick_once();
        cycle(1'b1, 1'b0, 1'b1);
        check_eq("mode_vs_tick_mode", int'(mode), 1);
        check_eq("mode_vs_tick_sec", int'(sec), 1);
        cycle(1'b0, 1'b0, 1'b0);
        // mode_btn beats a simultaneous inc.
        cycle(1'b1, 1'b1, 1'b0);
        check_eq("mode_vs_inc_hour", int'(hour), 1);
        cycle(1'b1, 1'b0, 1'b0);

        // inc_btn ignored in RUN; a held tick_in counts once.
        cycle(1'b0, 1'b1, 1'b0);
        check_eq("inc_in_run_min", int'(min), 0);
        repeat (10) cycle(1'b0, 1'b0, 1'b1);
        check_eq("held_tick_sec", int'(sec), 1);
        cycle(1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a minute edit.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b1, 1'b0);
        check_eq("pre_reset_mode", int'(mode), 2);
        tick_in = 1'b1;
        rst     = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;
        // tick_in already high at release counts once.
        cycle(1'b0, 1'b0, 1'b1);
        check_eq("post_reset_tick_sec", int'(sec), 1);
        cycle(1'b0, 1'b0, 1'b1);
        check_eq("post_reset_hold_sec", int'(sec), 1);

        // Random stimulus against the model.
        for (int i = 0; i < 4000; i++) begin
            cycle(1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)));
            n_cmp++;
            if (int'(hour) >= int'(HOUR_MOD) || int'(min) > 59 ||
                int'(sec) > 59 || int'(mode) == 3) begin
                n_err++;
                $display("FAIL range: got %0d:%0d:%0d mode %0d, required legal range",
                         hour, min, sec, mode);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 The block SHALL have parameter HOUR_MOD, default 24, giving the hour counter modulus (legal 12 or 24).
REQ-002 The block SHALL have parameter START_HOUR, default 0, giving the hour value loaded at reset.
REQ-003 The block SHALL have port clk  input  1  system clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-005 The block SHALL have port tick_in  input  1  divided clock from the upstream divider, synchronous to clk, used only as data.
REQ-006 The block SHALL have port mode_btn  input  1  single-clk pulse from a debounced button; advances the mode.
REQ-007 The block SHALL have port inc_btn  input  1  single-clk pulse from a debounced button; increments the selected field.
REQ-008 The block SHALL have port hour  output  5  current hour, 0..HOUR_MOD-1.
REQ-009 The block SHALL have port min  output  6  current minute, 0..59.
REQ-010 The block SHALL have port sec  output  6  current second, 0..59.
REQ-011 The block SHALL have port mode  output  2  FSM state: 0 RUN, 1 SET_HR, 2 SET_MIN; value 3 is never driven.
REQ-012 The block SHALL have port day_pulse  output  1  one-clk pulse on hour wrap-around in RUN.

Function
REQ-013 The block SHALL register tick_in into tick_d every clk cycle; a tick event is a cycle with tick_in=1 and tick_d=0.
REQ-014 The block SHALL NOT treat a high tick_in that persists for several cycles as more than one event.
REQ-015 In RUN, a tick event SHALL increment sec on the same clk edge that samples it, giving zero added latency.
REQ-016 sec SHALL wrap from 59 to 0 and increment min; min SHALL wrap from 59 to 0 and increment hour; hour SHALL wrap from HOUR_MOD-1 to 0.
REQ-017 day_pulse SHALL be 1 for exactly the one cycle after the edge at which hour wraps to 0 in RUN, and 0 otherwise.
REQ-018 The FSM SHALL step on mode_btn as follows: RUN->SET_HR, SET_HR->SET_MIN, SET_MIN->RUN; with no mode_btn the state holds.
REQ-019 In SET_HR and SET_MIN, tick events SHALL be ignored and sec SHALL hold its value.
REQ-020 In SET_HR, inc_btn SHALL increment hour modulo HOUR_MOD without carrying into any other field.
REQ-021 In SET_MIN, inc_btn SHALL increment min modulo 60 without carrying into hour.
REQ-022 The SET_MIN->RUN transition SHALL clear sec to 0 on the same edge.
REQ-023 inc_btn SHALL have no effect in RUN.
REQ-024 If mode_btn and a tick event occur in the same cycle in RUN, mode_btn SHALL win: the state changes and the tick is discarded.
REQ-025 If mode_btn and inc_btn occur in the same cycle in a set state, mode_btn SHALL win and inc_btn SHALL be ignored.
REQ-026 Manual increments SHALL NOT generate day_pulse.
REQ-027 All outputs SHALL be registered, and no output SHALL ever leave its legal range.

Reset
REQ-028 While rst=0, the block SHALL asynchronously force: hour=START_HOUR, min=0, sec=0, mode=RUN, day_pulse=0, tick_d=0.
REQ-029 A reset asserted during a set state SHALL discard the partial edit and return to RUN with the reset values.
REQ-030 After rst deasserts, a tick_in already high SHALL count as one event at the first clk edge (because tick_d=0).

Verification
REQ-031 Release reset, then apply 3 tick events -> sec=3, min=0, hour=0, mode=0.
REQ-032 Preload 23:59:59 in RUN, then apply 1 tick event -> 00:00:00 and day_pulse high for exactly 1 cycle.
REQ-033 Apply mode_btn, then inc_btn x25 (HOUR_MOD=24) -> hour=1 with min and sec unchanged; tick events in the meantime leave sec unchanged.
REQ-034 From SET_MIN at min=59, apply inc_btn -> min=0, hour unchanged; then apply mode_btn -> mode=RUN, sec=0.
REQ-035 In RUN, apply mode_btn and a tick event in the same cycle -> mode=1 and sec unchanged.
REQ-036 Hold tick_in high for 10 cycles -> sec increments exactly once; assert rst in SET_MIN -> all outputs return to reset values immediately, without waiting for a clk edge.
